cic_comb: RTL

CIC_COMB -- requirements
Module: cic_comb

---
 rtl/cic_comb.sv | 117 +++++++++++
 1 files changed

// File: rtl/cic_comb.sv
// CIC decimator comb section: N cascaded y = x - x[-M] stages at the low rate, then output truncation.
// Optional feature macro: CIC_COMB_ROUND_EN adds a round-half-up, saturating output register stage.
module cic_comb #(
   parameter int unsigned IN_WIDTH  = 22,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned N         = 3,
   parameter int unsigned M         = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic signed [IN_WIDTH-1:0]  din,
   input  logic                        din_valid,
   output logic signed [OUT_WIDTH-1:0] dout,
   output logic                        dout_valid
);

   localparam int unsigned SHIFT = IN_WIDTH - OUT_WIDTH;

   typedef logic signed [IN_WIDTH-1:0] sample_t;

   sample_t        y_q   [N];
   sample_t        y_d   [N];
   sample_t        dly_q [N][M];
   sample_t        dly_d [N][M];
   logic [N-1:0]   v_q;
   logic [N-1:0]   v_d;
   sample_t        x_c   [N];
   logic [N-1:0]   xv_c;

   // Stage inputs: stage 0 takes din, later stages take the previous stage register.
   always_comb begin
      x_c[0]  = din;
      xv_c[0] = din_valid;
      for (int unsigned k = 1; k < N; k++) begin
         x_c[k]  = y_q[k-1];
         xv_c[k] = v_q[k-1];
      end
   end

   // Each stage updates only when its input is valid; arithmetic wraps at IN_WIDTH bits.
   always_comb begin
      y_d   = y_q;
      dly_d = dly_q;
      v_d   = xv_c;
      for (int unsigned k = 0; k < N; k++) begin
         if (xv_c[k]) begin
            y_d[k]      = x_c[k] - dly_q[k][M-1];
            dly_d[k][0] = x_c[k];
            for (int unsigned j = 1; j < M; j++) begin
               dly_d[k][j] = dly_q[k][j-1];
            end
         end
      end
      if (rst || clr) begin
         v_d = '0;
         for (int unsigned k = 0; k < N; k++) begin
            y_d[k] = '0;
            for (int unsigned j = 0; j < M; j++) begin
               dly_d[k][j] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      y_q   <= y_d;
      dly_q <= dly_d;
      v_q   <= v_d;
   end

`ifdef CIC_COMB_ROUND_EN
   localparam int unsigned EXT_W = IN_WIDTH + 1;
   localparam int unsigned HALF  = 1 << (SHIFT - 1);
   localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

   logic [EXT_W-1:0]            ext_c;
   logic                        ovf_c;
   logic                        unused_c;
   logic signed [OUT_WIDTH-1:0] dout_q;
   logic signed [OUT_WIDTH-1:0] dout_d;
   logic                        dout_valid_q;
   logic                        dout_valid_d;

   // Adding a positive half-LSB can only overflow upward; that case saturates to +max.
   always_comb begin
      ext_c        = {y_q[N-1][IN_WIDTH-1], y_q[N-1]} + EXT_W'(HALF);
      ovf_c        = ext_c[IN_WIDTH] ^ ext_c[IN_WIDTH-1];
      unused_c     = ^ext_c[SHIFT-1:0];
      dout_d       = dout_q;
      dout_valid_d = v_q[N-1];
      if (v_q[N-1]) begin
         dout_d = ovf_c ? SAT_MAX : ext_c[IN_WIDTH-1:SHIFT];
      end
      if (rst || clr) begin
         dout_d       = '0;
         dout_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
`else
   logic unused_c;

   // Truncation toward negative infinity: keep the top OUT_WIDTH bits of the last stage register.
   assign dout       = y_q[N-1][IN_WIDTH-1:SHIFT];
   assign dout_valid = v_q[N-1];
   assign unused_c   = ^y_q[N-1][SHIFT-1:0];
`endif

endmodule
